// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU request arbiter.
package alu_arb_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_OP_W   = 3;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } alu_arb_state_e;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_OP_W-1:0]   op;
  } alu_req_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester, ALU and response channels of the arbiter; slave is the arbiter side.
interface alu_req_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  localparam int unsigned ID_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][ALU_DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0][ALU_DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0][ALU_OP_W-1:0]   req_op;

  logic                  alu_start;
  logic [ALU_DATA_W-1:0] alu_a;
  logic [ALU_DATA_W-1:0] alu_b;
  logic [ALU_OP_W-1:0]   alu_op;
  logic [ALU_DATA_W-1:0] alu_r;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [ALU_DATA_W-1:0] rsp_r;

  modport master (
    output req_valid, req_a, req_b, req_op, alu_r, rsp_ready,
    input  req_ready, alu_start, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_r
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_r, rsp_ready,
    output req_ready, alu_start, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_r
  );

endinterface

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request above 'last', wrapping.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] last,
  output logic [N-1:0]        gnt,
  output logic [idx_w(N)-1:0] gnt_idx
);

  localparam int unsigned IW = idx_w(N);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!found && req[IW'(idx)]) begin
        found             = 1'b1;
        gnt[IW'(idx)]     = 1'b1;
        gnt_idx           = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters, one transaction in flight at a time.
// Optional per-requester grant counters when ALU_ARB_STATS_EN is defined.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ALU_LAT = 2
) (
  input logic              clk,
  input logic              rst_n,
  alu_req_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] grant_cnt
`endif
);

  localparam int unsigned IW = idx_w(NUM_REQ);

  alu_arb_state_e        r_state;
  logic [IW-1:0]         r_last;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_alu_start;
  logic [ALU_DATA_W-1:0] r_alu_a;
  logic [ALU_DATA_W-1:0] r_alu_b;
  logic [ALU_OP_W-1:0]   r_alu_op;
  logic                  r_rsp_valid;
  logic [IW-1:0]         r_rsp_id;
  logic [ALU_DATA_W-1:0] r_rsp_r;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [IW-1:0]         w_gnt_idx;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_accept;
  alu_req_t              w_sel;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req    (bus.req_valid),
    .last   (r_last),
    .gnt    (w_gnt),
    .gnt_idx(w_gnt_idx)
  );

  // Ready is combinational so a dropped request is re-arbitrated in the same cycle.
  assign w_ready  = (r_state == IDLE && rst_n) ? w_gnt : '0;
  assign w_accept = |(bus.req_valid & w_ready);
  assign w_sel    = '{a: bus.req_a[w_gnt_idx], b: bus.req_b[w_gnt_idx],
                      op: bus.req_op[w_gnt_idx]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= IW'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_alu_start <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_r     <= '0;
    end else begin
      r_alu_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_a     <= w_sel.a;
            r_alu_b     <= w_sel.b;
            r_alu_op    <= w_sel.op;
            r_rsp_id    <= w_gnt_idx;
            r_last      <= w_gnt_idx;
            r_cnt       <= CNT_W'(ALU_LAT);
            r_alu_start <= 1'b1;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_rsp_r     <= bus.alu_r;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.alu_start = r_alu_start;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_r     = r_rsp_r;

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_grant_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept && w_gnt[i] && r_grant_cnt[i] != 16'hFFFF) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares one 32-bit ALU (operands `a`, `b`, 3-bit `op`, result `r`) between up to `NUM_REQ` requesters. It grants one requester at a time by round-robin and registers that requester's operands onto the ALU inputs. It samples `r` after a fixed configurable latency and returns the result with the requester index on a single response channel with backpressure. The block sits between the testbench/host-side requesters and the ALU interface.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..8.
- `ALU_LAT`, 2: cycles from operands stable on `alu_*` to `alu_r` valid, 0..15.
- `clk`  in  1: clock; all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ: per-requester request.
- `req_ready`  out  NUM_REQ: one-hot grant/accept.
- `req_a`, `req_b`  in  NUM_REQ x 32: operands per requester.
- `req_op`  in  NUM_REQ x 3: opcode per requester, passed through unchecked.
- `alu_start`  out  1: one-cycle pulse when new operands are driven.
- `alu_a`, `alu_b`  out  32: registered operands to the ALU.
- `alu_op`  out  3: registered opcode to the ALU.
- `alu_r`  in  32: ALU result.
- `rsp_valid`  out  1: response available.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_id`  out  $clog2(NUM_REQ) (min 1): index of the granted requester.
- `rsp_r`  out  32: captured result.

## Operation
- FSM has three states.
  - IDLE: combinational round-robin pick among `req_valid`, starting at `last_grant+1` mod `NUM_REQ`. `req_ready[g]` is high for the winner only. On `req_valid[g] & req_ready[g]`: register `req_a`/`req_b`/`req_op` into `alu_a`/`alu_b`/`alu_op`, set `rsp_id=g`, `last_grant=g`, latency counter = `ALU_LAT`, pulse `alu_start`, go to EXEC.
  - EXEC: `alu_*` are held stable. If counter==0, capture `alu_r` into `rsp_r`, set `rsp_valid`, go to RESP. Otherwise decrement.
  - RESP: hold `rsp_valid`/`rsp_id`/`rsp_r` stable. On `rsp_ready` clear `rsp_valid` and go to IDLE.
- `req_ready` is 0 outside IDLE and while `rst_n` is low.
- A requester may drop `req_valid` before its handshake; no transaction occurs and arbitration re-evaluates in the same cycle.
- The winner is the first asserted bit scanning upward from `last_grant+1` with wrap-around. With `NUM_REQ=1` the single requester always wins.
- Only one transaction is in flight. No new request is accepted until the response handshake completes.
- `alu_a`/`alu_b`/`alu_op` keep their last values in IDLE and RESP.

## Timing
- Reset values: state IDLE; `last_grant = NUM_REQ-1` (requester 0 wins first); `req_ready=0`, `alu_start=0`, `alu_a=alu_b=0`, `alu_op=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_r=0`.
- Request handshake in cycle T: operands on `alu_*` and `alu_start=1` in cycle T+1.
- `alu_r` is sampled at the end of cycle T+1+ALU_LAT. `rsp_valid` rises in cycle T+2+ALU_LAT.
- `rsp_ready` held high: response handshake in T+2+ALU_LAT, next request can be accepted in T+3+ALU_LAT. Peak throughput is one op per ALU_LAT+3 cycles.
- `ALU_LAT=0`: sample at the end of T+1, i.e. the ALU is treated as combinational.
- Reset asserted mid-transaction: all state returns to reset values immediately. The in-flight result is discarded and no response is produced.

## Configuration
- `ALU_ARB_STATS_EN` defined: adds output `grant_cnt` (NUM_REQ x 16). Entry i increments on each request handshake of requester i and saturates at 16'hFFFF. Reset value is 0.
- `ALU_ARB_STATS_EN` undefined: the port and counters do not exist. All other behaviour is identical.

## Structure
- Package `alu_arb_pkg`:
  - `ALU_DATA_W=32`, `ALU_OP_W=3`.
  - `alu_arb_state_e` {IDLE, EXEC, RESP}.
  - `alu_req_t` struct {a, b, op}.
- Sub-module `rr_arbiter`: parameter `N`; inputs `req[N]`, `last[$clog2(N)]`; outputs one-hot `gnt[N]` and `gnt_idx`. Purely combinational, instantiated once.

## Test plan
- Single request: requester 0 sends a=32'h5, b=32'h3, op=3'd0, ALU_LAT=2, ALU model r=a+b -> `alu_start` at T+1, `rsp_valid` at T+4 with `rsp_r`=32'h8, `rsp_id`=0.
- All four requesters valid continuously, `rsp_ready`=1 -> grant order 0,1,2,3,0; each next accept occurs 5 cycles after the previous one.
- Backpressure: `rsp_ready`=0 for 6 cycles after `rsp_valid` -> `rsp_r`/`rsp_id` stable, `req_ready` all 0, then IDLE one cycle after `rsp_ready`=1.
- ALU_LAT=0 with ALU model r=a^b, a=32'hFFFF0000, b=32'h0F0F0F0F -> `rsp_r`=32'hF0F00F0F, `rsp_valid` at T+2.
- `rst_n` pulsed low during EXEC -> `rsp_valid` never asserts; the next request after reset is granted to requester 0 even if requester 2 was last served.
- With `ALU_ARB_STATS_EN`: 3 transactions from requester 1 and 1 from requester 3 -> `grant_cnt` = {0,3,0,1}.
